// File: rtl/gene_tick_counter.sv
// Counts rising edges of gene in a two-digit BCD counter with tick/carry pulses; GENE_CNT_SAT_EN selects saturation.
// Latency: an edge sampled at clock N is reflected in ones/tens/tick from cycle N+1.
// Backpressure: none; edges seen while en is low are dropped, never queued.
module gene_tick_counter #(
  parameter int unsigned ONES_MAX = 9,
  parameter int unsigned TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gene,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tick,
  output logic       carry
);

  localparam logic [3:0] ONES_M = ONES_MAX[3:0];
  localparam logic [3:0] TENS_M = TENS_MAX[3:0];

  logic       gene_q;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       tick_q, tick_d;
  logic       carry_q, carry_d;
  logic       gene_rise;

  assign gene_rise = gene & ~gene_q;

  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    tick_d  = 1'b0;
`ifdef GENE_CNT_SAT_EN
    carry_d = carry_q;
`else
    carry_d = 1'b0;
`endif
    if (clr) begin
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      carry_d = 1'b0;
    end else if (en && gene_rise) begin
      tick_d = 1'b1;
      if (ones_q < ONES_M) begin
        ones_d = ones_q + 4'd1;
      end else if (tens_q < TENS_M) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
`ifdef GENE_CNT_SAT_EN
        // Already at the terminal count: digits hold, tick still reports the edge.
        ones_d = ones_q;
        tens_d = tens_q;
`else
        ones_d  = 4'd0;
        tens_d  = 4'd0;
        carry_d = 1'b1;
`endif
      end
`ifdef GENE_CNT_SAT_EN
      carry_d = (ones_d == ONES_M) && (tens_d == TENS_M);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gene_q  <= 1'b0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      // Edge history tracks gene even across clr so a held level is not recounted.
      gene_q  <= gene;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign ones  = ones_q;
  assign tens  = tens_q;
  assign tick  = tick_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_gene_tick_counter.sv
// Directed bench for gene_tick_counter: table-driven vectors plus multi-cycle sequences.
// A second instance with ONES_MAX=4, TENS_MAX=1 shares the inputs for the parameter check.
module tb_gene_tick_counter;

  logic       clk = 1'b0;
  logic       rst, gene, en, clr;
  logic [3:0] ones, tens, ones2, tens2;
  logic       tick, carry, tick2, carry2;

  int total = 0;
  int bad   = 0;

  gene_tick_counter dut (
    .clk(clk), .rst(rst), .gene(gene), .en(en), .clr(clr),
    .ones(ones), .tens(tens), .tick(tick), .carry(carry)
  );

  gene_tick_counter #(.ONES_MAX(4), .TENS_MAX(1)) dut_small (
    .clk(clk), .rst(rst), .gene(gene), .en(en), .clr(clr),
    .ones(ones2), .tens(tens2), .tick(tick2), .carry(carry2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, gene, en, clr;
    logic [3:0] e_ones, e_tens;
    logic       e_tick, e_carry;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic g, input logic e, input logic c);
    @(negedge clk);
    rst = r; gene = g; en = e; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input int eo, input int et, input int tk, input int cy);
    chk({nm, ".ones"},  int'(ones),  eo);
    chk({nm, ".tens"},  int'(tens),  et);
    chk({nm, ".tick"},  int'(tick),  tk);
    chk({nm, ".carry"}, int'(carry), cy);
  endtask

  initial begin
    int ticks;
    rst = 1'b1; gene = 1'b0; en = 1'b0; clr = 1'b0;

    //            rst  gene en  clr  ones  tens  tick carry
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].gene, vecs[i].en, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_ones, vecs[i].e_tens,
              vecs[i].e_tick, vecs[i].e_carry);
    end

    // Level vs edge: 5 high, 3 low, three times.
    step(1, 0, 0, 0);
    ticks = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) begin
        step(0, (c < 5), 1, 0);
        if (tick) ticks++;
      end
    end
    chk("level.ticks", ticks, 3);
    chk_all("level", 3, 0, 0, 0);

    // Wrap: 60 isolated pulses spaced 7 cycles.
    step(1, 0, 0, 0);
    for (int k = 1; k <= 60; k++) begin
      step(0, 1, 1, 0);
      if (k < 60) chk_all($sformatf("wrap%0d", k), k % 10, k / 10, 1, 0);
      else        chk_all("wrap60", 0, 0, 1, 1);
      step(0, 0, 1, 0);
      if (k >= 59) chk_all($sformatf("wrap%0d.after", k), (k % 60) % 10, (k % 60) / 10, 0, 0);
      for (int c = 0; c < 5; c++) step(0, 0, 1, 0);
    end

    // Enable gating: 10 pulses discarded, 4 counted, then en rising mid-pulse.
    step(1, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      step(0, 1, (k >= 10), 0);
      step(0, 0, (k >= 10), 0);
    end
    chk_all("gate", 4, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk_all("gate.midpulse", 4, 0, 0, 0);
    step(0, 0, 1, 0);

    // Clear collision at 37.
    step(1, 0, 0, 0);
    for (int k = 0; k < 37; k++) begin
      step(0, 1, 1, 0);
      step(0, 0, 1, 0);
    end
    chk_all("clr.pre", 7, 3, 0, 0);
    step(0, 1, 1, 1);
    chk_all("clr.hit", 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 1, 0);
      chk_all($sformatf("clr.hold%0d", c), 0, 0, 0, 0);
    end
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    chk_all("clr.fresh", 1, 0, 1, 0);

    // rst mid-count with an edge present.
    step(0, 0, 1, 0);
    step(1, 1, 1, 0);
    chk_all("rst.mid", 0, 0, 0, 0);

    // Small instance: 00..04,10..14,00 with carry on the 10th edge.
    step(1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 1, 1, 0);
      chk($sformatf("small%0d.ones", k),  int'(ones2),  (k % 10) % 5);
      chk($sformatf("small%0d.tens", k),  int'(tens2),  (k % 10) / 5);
      chk($sformatf("small%0d.tick", k),  int'(tick2),  1);
      chk($sformatf("small%0d.carry", k), int'(carry2), (k == 10) ? 1 : 0);
      step(0, 0, 1, 0);
      chk($sformatf("small%0d.carry_off", k), int'(carry2), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
